// File: rtl/i2c_timing_defs.sv
// Shared timebase constants for the I2C controller: default divider ratios,
// counter widths, and the standard timeout sizes the downstream timers load.
package i2c_timing_defs;

   localparam int DEF_CLK_DIV_US = 33;
   localparam int DEF_US_PER_MS  = 1000;
   localparam int DEF_MS_PER_S   = 1000;

   localparam int PRE_W = 8;
   localparam int US_W  = 10;
   localparam int MS_W  = 10;
   localparam int UP_W  = 16;

   // Timeout sizes in ms, counted on tick_ms by the programmable timers
   localparam int TO_BUS_STUCK_MS = 35;
   localparam int TO_LOW_SEXT_MS  = 25;
   localparam int TO_LOW_MEXT_MS  = 10;
   localparam int TO_BUS_IDLE_MS  = 50;

endpackage

// File: rtl/tick_mod_cnt.sv
// Modulo-MOD event counter used for the us->ms and ms->s stages.
// wrap is combinational: high on the increment that returns cnt to 0.
module tick_mod_cnt #(
   parameter int WIDTH = 10,
   parameter int MOD   = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic             wrap,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign wrap = inc && (cnt_q == LAST);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (wrap)
         cnt_d = '0;
      else if (inc)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2c_tick_gen.sv
// Prescaler chain producing 1 us / 1 ms / 1 s strobes plus a seconds uptime.
// TICK_TRIM_EN adds a runtime-loadable cycles-per-us divider (div_load/div_val).
module i2c_tick_gen
   import i2c_timing_defs::*;
#(
   parameter int CLK_DIV_US = DEF_CLK_DIV_US,
   parameter int US_PER_MS  = DEF_US_PER_MS,
   parameter int MS_PER_S   = DEF_MS_PER_S
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            run,
   input  logic            clr,
   output logic            tick_us,
   output logic            tick_ms,
   output logic            tick_s,
   output logic [UP_W-1:0] uptime_s
`ifdef TICK_TRIM_EN
   ,
   input  logic             div_load,
   input  logic [PRE_W-1:0] div_val
`endif
);

   localparam logic [PRE_W-1:0] DIV_LAST = PRE_W'(CLK_DIV_US - 1);

   logic [PRE_W-1:0] pre_q, pre_d, div_cur;
   logic             tick_us_q, tick_us_d;
   logic             tick_ms_q, tick_ms_d;
   logic             tick_s_q, tick_s_d;
   logic [UP_W-1:0]  up_q, up_d;
   logic             load_ok, us_wrap, ms_wrap, s_wrap;
   logic [US_W-1:0]  us_cnt_unused;
   logic [MS_W-1:0]  ms_cnt_unused;

`ifdef TICK_TRIM_EN
   logic [PRE_W-1:0] div_q, div_d;

   always_comb begin
      load_ok = div_load && (div_val != '0);
      div_d   = load_ok ? div_val : div_q;
   end

   // Reset restores the build-time divider; clr leaves a trimmed value alone
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)
         div_q <= DIV_LAST;
      else
         div_q <= div_d;
   end

   assign div_cur = div_q;
`else
   assign load_ok = 1'b0;
   assign div_cur = DIV_LAST;
`endif

   // A divider load restarts the prescaler, so that edge never terminates a period
   assign us_wrap = run && !load_ok && (pre_q == div_cur);

   tick_mod_cnt #(.WIDTH(US_W), .MOD(US_PER_MS)) u_us_cnt (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .inc   (us_wrap),
      .clr   (clr),
      .wrap  (ms_wrap),
      .cnt   (us_cnt_unused)
   );

   tick_mod_cnt #(.WIDTH(MS_W), .MOD(MS_PER_S)) u_ms_cnt (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .inc   (ms_wrap),
      .clr   (clr),
      .wrap  (s_wrap),
      .cnt   (ms_cnt_unused)
   );

   always_comb begin
      pre_d     = pre_q;
      up_d      = up_q;
      tick_us_d = 1'b0;
      tick_ms_d = 1'b0;
      tick_s_d  = 1'b0;
      if (clr) begin
         pre_d = '0;
         up_d  = '0;
      end else begin
         tick_us_d = us_wrap;
         tick_ms_d = ms_wrap;
         tick_s_d  = s_wrap;
         if (load_ok)
            pre_d = '0;
         else if (us_wrap)
            pre_d = '0;
         else if (run)
            pre_d = pre_q + 1'b1;
         if (s_wrap)
            up_d = up_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         pre_q     <= '0;
         up_q      <= '0;
         tick_us_q <= 1'b0;
         tick_ms_q <= 1'b0;
         tick_s_q  <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         up_q      <= up_d;
         tick_us_q <= tick_us_d;
         tick_ms_q <= tick_ms_d;
         tick_s_q  <= tick_s_d;
      end
   end

   assign tick_us  = tick_us_q;
   assign tick_ms  = tick_ms_q;
   assign tick_s   = tick_s_q;
   assign uptime_s = up_q;

endmodule

// File: tb/tb_i2c_tick_gen.sv
// Scoreboard bench for i2c_tick_gen with DIV=4, US_PER_MS=3, MS_PER_S=2
// (tick_us every 4, tick_ms every 12, tick_s every 24 running cycles).
module tb_i2c_tick_gen;

   localparam int DIV = 4;
   localparam int UPM = 3;
   localparam int MPS = 2;

   logic        clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        run = 1'b0;
   logic        clr = 1'b0;
   logic        tick_us, tick_ms, tick_s;
   logic [15:0] uptime_s;
   logic        div_load = 1'b0;
   logic [7:0]  div_val = 8'd0;

   always #5 clk = ~clk;

   i2c_tick_gen #(.CLK_DIV_US(DIV), .US_PER_MS(UPM), .MS_PER_S(MPS)) dut (
      .sys_clk   (clk),
      .sys_rst_n (sys_rst_n),
      .run       (run),
      .clr       (clr),
      .tick_us   (tick_us),
      .tick_ms   (tick_ms),
      .tick_s    (tick_s),
      .uptime_s  (uptime_s)
`ifdef TICK_TRIM_EN
      ,
      .div_load  (div_load),
      .div_val   (div_val)
`endif
   );

   typedef struct {
      logic        us;
      logic        ms;
      logic        s;
      logic [15:0] up;
      int          phase;
      int          edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: period counter, count of us ticks since clr/reset
   int          pc = 0;
   int          nus = 0;
   int          period = DIV;
   logic [15:0] up_m = 16'd0;
   int          phase = 0;
   int          edge_no = 0;

   task automatic step(input logic r_n, input logic c, input logic rn,
                       input logic ld = 1'b0, input logic [7:0] dv = 8'd0,
                       input logic frc = 1'b0);
      exp_t e;
      @(negedge clk);
      if (frc) begin
         #1;
         force dut.up_q = 16'hFFFE;
         #1;
         release dut.up_q;
         up_m = 16'hFFFE;
      end
      sys_rst_n = r_n;
      clr       = c;
      run       = rn;
      div_load  = ld;
      div_val   = dv;
      e.us = 1'b0; e.ms = 1'b0; e.s = 1'b0;
      if (!r_n) begin
         pc = 0; nus = 0; up_m = 16'd0; period = DIV; edge_no = 0;
      end else begin
         edge_no++;
         if (c) begin
            pc = 0; nus = 0; up_m = 16'd0; edge_no = 0;
            if (ld && dv != 8'd0) period = int'(dv) + 1;
         end else if (ld && dv != 8'd0) begin
            period = int'(dv) + 1;
            pc = 0;
         end else if (rn) begin
            pc++;
            if (pc == period) begin
               pc = 0;
               e.us = 1'b1;
               nus++;
               if (nus % UPM == 0) e.ms = 1'b1;
               if (nus % (UPM * MPS) == 0) begin
                  e.s = 1'b1;
                  up_m = up_m + 16'd1;
               end
            end
         end
      end
      e.up      = up_m;
      e.phase   = phase;
      e.edge_no = edge_no;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic run_n(input int n, input logic rn);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, rn);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (tick_us !== e.us || tick_ms !== e.ms || tick_s !== e.s || uptime_s !== e.up) begin
            n_err++;
            $display("FAIL phase%0d edge%0d: got us/ms/s/up=%b/%b/%b/%h need %b/%b/%b/%h",
                     e.phase, e.edge_no, tick_us, tick_ms, tick_s, uptime_s,
                     e.us, e.ms, e.s, e.up);
         end
      end
   end

   initial begin
      // Reset state, then free run: us at 4,8,..; ms at 12,24; s + uptime=1 at 24
      phase = 0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      run_n(26, 1'b1);

      // Pause: prescaler held at 2 through edges 7..16, next tick_us at 18
      phase = 1;
      step(1'b1, 1'b1, 1'b0);
      run_n(6, 1'b1);
      run_n(10, 1'b0);
      run_n(8, 1'b1);

      // clr coincident with terminal count at edge 12
      phase = 2;
      step(1'b1, 1'b1, 1'b0);
      run_n(11, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      run_n(6, 1'b1);

      // Synchronous reset mid-period
      phase = 3;
      step(1'b1, 1'b1, 1'b0);
      run_n(9, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      run_n(6, 1'b1);

      // Uptime wrap 0xFFFE -> 0xFFFF -> 0x0000
      phase = 4;
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
      run_n(50, 1'b1);

`ifdef TICK_TRIM_EN
      // Trim: load 7 at edge 5 -> ticks at 13, 21; div_val=0 ignored; reset restores 4
      phase = 5;
      step(1'b1, 1'b1, 1'b0);
      run_n(4, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 8'd7);
      run_n(17, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
      run_n(10, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      run_n(9, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      run_n(9, 1'b1);
`endif

      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending entries, need 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
